// File: rtl/pc_fetch_ctrl.sv
// Next-PC sequencing for the instruction-fetch PC register: redirect priority,
// stalled-branch buffering, fetch-address checking, flush and redirect counting.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter logic [31:0] IM_TOP     = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] next_pc,
  output logic        pc_en,
  output logic        cut,
  output logic        flush,
  output logic        pend,
  output logic        fetch_exc,
  output logic [15:0] redirect_cnt
);

  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pend_tgt_q, pend_tgt_d;
  logic              flush_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              redir_c;
  logic              forced_c;

  assign forced_c = exc_req || eret_req;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a forced redirect always discards any buffered branch
  always_comb begin
    state_d    = state_q;
    pend_tgt_d = pend_tgt_q;
    if (forced_c) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (br_valid && stall) begin
            state_d    = PEND;
            pend_tgt_d = br_target;
          end
        end
        PEND: begin
          if (!stall) begin
            state_d = RUN;
          end else if (br_valid) begin
            pend_tgt_d = br_target;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Output logic: next-PC source selection by priority
  always_comb begin
    next_pc = PC_W'(pc + 32'd4);
    pc_en   = 1'b0;
    cut     = 1'b0;
    redir_c = 1'b0;
    if (reset) begin
      next_pc = RESET_PC;
    end else if (exc_req) begin
      next_pc = HANDLER_PC;
      cut     = 1'b1;
    end else if (eret_req) begin
      next_pc = epc;
      cut     = 1'b1;
    end else if (state_q == PEND && !stall) begin
      next_pc = pend_tgt_q;
      pc_en   = 1'b1;
      redir_c = 1'b1;
    end else if (br_valid && !stall) begin
      next_pc = br_target;
      pc_en   = 1'b1;
      redir_c = 1'b1;
    end else begin
      pc_en   = !stall;
    end
  end

  // Saturating count of applied redirects
  always_comb begin
    cnt_d = cnt_q;
    if ((cut || redir_c) && cnt_q != CNT_MAX) begin
      cnt_d = CNT_W'(cnt_q + 16'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_tgt_q <= '0;
      flush_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      pend_tgt_q <= pend_tgt_d;
      flush_q    <= cut;
      cnt_q      <= cnt_d;
    end
  end

  assign flush        = flush_q;
  assign pend         = (state_q == PEND);
  assign redirect_cnt = cnt_q;
  assign fetch_exc    = (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_TOP);

  // A new branch arriving as the buffered one is released is dropped
  a_no_dropped_branch : assert property (@(posedge clk) disable iff (reset)
    !(state_q == PEND && br_valid && !stall && !exc_req && !eret_req))
    else $error("pc_fetch_ctrl: branch dropped while releasing buffered target");

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: directed plan plus randomized traffic,
// expected outputs from a behavioural model of the redirect rules.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] IM_BASE    = 32'h0000_3000;
  localparam logic [31:0] IM_TOP     = 32'h0000_6FFC;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        stall;
  logic        br_valid;
  logic [31:0] br_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] next_pc;
  logic        pc_en;
  logic        cut;
  logic        flush;
  logic        pend;
  logic        fetch_exc;
  logic [15:0] redirect_cnt;

  pc_fetch_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .stall        (stall),
    .br_valid     (br_valid),
    .br_target    (br_target),
    .exc_req      (exc_req),
    .eret_req     (eret_req),
    .epc          (epc),
    .next_pc      (next_pc),
    .pc_en        (pc_en),
    .cut          (cut),
    .flush        (flush),
    .pend         (pend),
    .fetch_exc    (fetch_exc),
    .redirect_cnt (redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] npc;
    logic        en;
    logic        cut;
    logic        flush;
    logic        pend;
    logic        fexc;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_pend;
  logic [31:0] m_tgt;
  bit          m_flush;
  int unsigned m_cnt;
  logic [31:0] pc_r;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the queued expectation each cycle
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      cmp("next_pc",      next_pc,             e.npc);
      cmp("pc_en",        32'(pc_en),          32'(e.en));
      cmp("cut",          32'(cut),            32'(e.cut));
      cmp("flush",        32'(flush),          32'(e.flush));
      cmp("pend",         32'(pend),           32'(e.pend));
      cmp("fetch_exc",    32'(fetch_exc),      32'(e.fexc));
      cmp("redirect_cnt", 32'(redirect_cnt),   32'(e.cnt));
    end
  end

  // One cycle: drive inputs, predict outputs, advance model and PC register
  task automatic step(input bit rst, input bit st, input bit br, input logic [31:0] tgt,
                      input bit ex, input bit er, input logic [31:0] ep);
    exp_t e;
    bit   redir;
    logic [31:0] pc_nx;
    reset = rst; stall = st; br_valid = br; br_target = tgt;
    exc_req = ex; eret_req = er; epc = ep; pc = pc_r;

    e.flush = m_flush;
    e.pend  = m_pend;
    e.cnt   = 16'(m_cnt);
    e.fexc  = (pc_r % 4 != 0) || !(pc_r >= IM_BASE && pc_r <= IM_TOP);
    e.en = 1'b0; e.cut = 1'b0; redir = 1'b0;
    if (rst)                begin e.npc = RESET_PC; end
    else if (ex)            begin e.npc = HANDLER_PC; e.cut = 1'b1; end
    else if (er)            begin e.npc = ep; e.cut = 1'b1; end
    else if (m_pend && !st) begin e.npc = m_tgt; e.en = 1'b1; redir = 1'b1; end
    else if (br && !st)     begin e.npc = tgt; e.en = 1'b1; redir = 1'b1; end
    else                    begin e.npc = pc_r + 32'd4; e.en = !st; end
    sb_q.push_back(e);

    if (rst) begin
      m_pend = 1'b0; m_tgt = '0; m_flush = 1'b0; m_cnt = 0; pc_nx = RESET_PC;
    end else begin
      m_flush = e.cut;
      if ((e.cut || redir) && m_cnt < 32'hFFFF) m_cnt++;
      if (e.cut || !st) m_pend = 1'b0;
      else if (br) begin m_pend = 1'b1; m_tgt = tgt; end
      pc_nx = (e.cut || e.en) ? e.npc : pc_r;
    end
    @(posedge clk);
    #1;
    pc_r = pc_nx;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, 0, '0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fexc_pcs [4];
    fexc_pcs[0] = 32'h0000_3002; fexc_pcs[1] = 32'h0000_7000;
    fexc_pcs[2] = 32'h0000_2FFC; fexc_pcs[3] = 32'h0000_6FFC;

    reset = 1'b1; stall = 1'b0; br_valid = 1'b0; br_target = '0;
    exc_req = 1'b0; eret_req = 1'b0; epc = '0; pc = RESET_PC;
    pc_r = RESET_PC; m_pend = 1'b0; m_tgt = '0; m_flush = 1'b0; m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset then sequential fetch to 0x3010
    step(1, 0, 0, '0, 0, 0, '0);
    idle(4);

    // Branch buffered across a 3-cycle stall
    step(0, 1, 1, 32'h0000_3100, 0, 0, '0);
    step(0, 1, 0, '0, 0, 0, '0);
    step(0, 1, 0, '0, 0, 0, '0);
    step(0, 0, 0, '0, 0, 0, '0);
    idle(1);

    // Exception overrides stall, then one-cycle flush
    pc_r = 32'h0000_3020;
    step(0, 1, 0, '0, 1, 0, '0);
    idle(2);

    // eret discards a buffered target
    step(0, 1, 1, 32'h0000_3200, 0, 0, '0);
    step(0, 1, 0, '0, 0, 1, 32'h0000_3024);
    idle(2);

    // exception beats eret; fetch-address checks
    step(0, 0, 0, '0, 1, 1, 32'h0000_3050);
    for (int i = 0; i < 4; i++) begin
      pc_r = fexc_pcs[i];
      step(0, 1, 0, '0, 0, 0, '0);
    end

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      bit rst, st, br, ex, er;
      logic [31:0] tgt, ep;
      rst = ($urandom % 64) == 0;
      st  = ($urandom % 3) == 0;
      br  = ($urandom % 4) == 0;
      ex  = ($urandom % 20) == 0;
      er  = ($urandom % 20) == 0;
      tgt = ($urandom % 8 == 0) ? $urandom : (IM_BASE + 4 * ($urandom % 4096));
      ep  = IM_BASE + 4 * ($urandom % 4096);
      if (m_pend && !st && !ex && !er && !rst) br = 1'b0;
      if ($urandom % 16 == 0) pc_r = ($urandom % 2 == 0) ? $urandom : fexc_pcs[$urandom % 4];
      step(rst, st, br, tgt, ex, er, ep);
    end

    // Drive the counter to one below saturation, then saturate with branches
    while (m_cnt < 32'hFFFE) step(0, 0, 0, '0, 1, 0, '0);
    step(0, 0, 1, 32'h0000_3400, 0, 0, '0);
    step(0, 0, 1, 32'h0000_3500, 0, 0, '0);
    step(0, 0, 1, 32'h0000_3600, 0, 0, '0);
    idle(2);

    // Reset while a branch is buffered
    step(0, 1, 1, 32'h0000_3300, 0, 0, '0);
    step(0, 1, 0, '0, 0, 0, '0);
    step(1, 1, 0, '0, 0, 0, '0);
    idle(2);

    for (int i = 0; i < 4 && sb_q.size() != 0; i++) @(negedge clk);
    #2;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
